pipe_if_stage: RTL and testbench
================================

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 The module SHALL use the following ports, one per line as name, direction, width, meaning:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pcsource  in  2  next-PC select from the ID-stage control unit: 00 = pc+4, 01 = bpc, 10 = da (jr), 11 = jpc.
- bpc  in  32  branch target from ID.
- da  in  32  jr target (forwarded rs value) from ID.
- jpc  in  32  j/jal target from ID.
- wpcir  in  1  1 = ID consumes d_inst this cycle; 0 = load-use stall.
- imem_addr  out  32  fetch address; equals pc.
- imem_req  out  1  fetch request.
- imem_rdata  in  32  instruction word; valid when imem_ack = 1.
- imem_ack  in  1  fetch complete, one cycle, only while imem_req = 1.
- pc  out  32  current fetch PC.
- d_pc4  out  32  IF/ID register: PC+4 of d_inst.
- d_inst  out  32  IF/ID register: instruction presented to the decoder.
- d_valid  out  1  IF/ID register: 1 = real instruction, 0 = bubble.
REQ-002 Clocking is fixed: one clock; reset is synchronous and active-high.

Function
REQ-003 The fetch FSM SHALL have two states. In FETCH, imem_req = 1 and imem_addr = pc. In HOLD, imem_req = 0 and a fetched word is parked in hold_inst.
REQ-004 "fetched" SHALL mean either state FETCH with imem_ack = 1 (word = imem_rdata) or state HOLD (word = hold_inst).
REQ-005 "redirect" SHALL mean wpcir = 1 and d_valid = 1 and pcsource != 00. The redirect target T is bpc, da, or jpc as selected by pcsource.
REQ-006 The stage SHALL implement branch delay-slot semantics: a redirect applies to the fetch after the instruction currently in IF, and that instruction is never flushed.
REQ-007 If wpcir = 1 and fetched:
- d_inst <= word, d_pc4 <= pc+4, d_valid <= 1.
- pc <= T if redirect; else pend_pc if pend_valid; else pc+4.
- pend_valid <= 0; state <= FETCH.
REQ-008 If wpcir = 1 and not fetched:
- d_inst <= 0 (nop), d_valid <= 0, d_pc4 holds.
- pc holds.
- If redirect: pend_valid <= 1, pend_pc <= T.
REQ-009 If wpcir = 0:
- d_pc4, d_inst, d_valid and pc hold.
- pcsource is ignored.
- If imem_ack arrives in FETCH: hold_inst <= imem_rdata, state <= HOLD.
REQ-010 Redirect and pend_valid SHALL never be true together, because pend_valid implies d_valid = 0. No priority logic beyond REQ-007 is required.
REQ-011 PC arithmetic SHALL be 32-bit modulo 2^32: pc+4 from 0xFFFFFFFC wraps to 0x00000000. Targets are used unmodified.
REQ-012 imem_addr SHALL stay stable from imem_req assertion until imem_ack. pc SHALL change only on the cycle an ack or HOLD word is consumed.

Reset
REQ-013 While reset = 1, the following SHALL apply at each clock edge:
- pc <= 0, d_pc4 <= 0, d_inst <= 0, d_valid <= 0.
- pend_valid <= 0, pend_pc <= 0, hold_inst <= 0, state <= FETCH.
- imem_req SHALL be forced to 0 combinationally.
REQ-014 Reset mid-fetch SHALL abandon the transaction. Any imem_ack during a reset cycle SHALL be ignored, and the instruction memory SHALL share the same reset.

Structure
REQ-015 A shared package pipe_pkg SHALL hold:
- pcsource encodings PCSRC_PC4, PCSRC_BR, PCSRC_JR, PCSRC_J;
- NOP_INST = 32'h0 and RESET_PC = 32'h0;
- the FSM state type (FETCH, HOLD).
REQ-016 Next-PC target selection (the pcsource mux to T) SHALL be one combinational sub-module, pipe_npc_sel. The FSM, PC, pending and IF/ID registers SHALL stay in pipe_if_stage.

Verification
REQ-017 Straight line: reset released, ack every cycle, wpcir = 1, pcsource = 00 -> pc 0,4,8,... and d_pc4 = 4,8,12 one cycle after each ack, d_valid = 1.
REQ-018 Branch with delay slot: beq at 0x10 in ID, pcsource = 01, bpc = 0x40, slot at 0x14 acked the same cycle -> d_inst = word@0x14 and next pc = 0x40.
REQ-019 Late slot: jr redirect (da = 0x80) while the slot fetch is not acked -> d_valid = 0, pend_valid = 1; slot acked 3 cycles later -> d_inst = slot and pc = 0x80.
REQ-020 Stall: wpcir = 0 for 2 cycles with ack in the first -> imem_req = 0 during the second cycle, d_* and pc unchanged; wpcir = 1 -> held word delivered, then FETCH at pc+4.
REQ-021 Reset mid-fetch: reset asserted while req is pending with pc = 0x24 -> next cycle pc = 0, d_valid = 0, imem_req = 0; an ack during reset is ignored.
REQ-022 Wrap: pc = 0xFFFFFFFC with ack and pcsource = 00 -> pc = 0x00000000 and d_pc4 = 0x00000000.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and types for the instruction-fetch stage.
package pipe_pkg;

    // Next-PC select values driven by the ID-stage control unit
    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // FETCH: request outstanding on the instruction bus
    // HOLD : a fetched word is parked while ID is stalled
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory request/acknowledge bus seen by the fetch stage.
interface pipe_if_stage_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/pipe_npc_sel.sv
// Redirect target mux: picks branch, jr or jump target from pcsource.
module pipe_npc_sel
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic [31:0] target
);

    // Targets pass through unmodified; the pc+4 case never redirects
    always_comb begin
        target = bpc;
        case (pcsource)
            PCSRC_BR: target = bpc;
            PCSRC_JR: target = da;
            PCSRC_J:  target = jpc;
            default:  target = bpc;
        endcase
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage: fetch FSM, PC, pending redirect and IF/ID register.
// Redirects take effect after the delay-slot instruction already in IF.
//
//   state | meaning
//   FETCH | imem_req high, waiting for imem_ack at address pc
//   HOLD  | word acked during an ID stall, parked in hold_inst
module pipe_if_stage
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        pcsource,
    input  logic [31:0]       bpc,
    input  logic [31:0]       da,
    input  logic [31:0]       jpc,
    input  logic              wpcir,
    pipe_if_stage_if.master   imem,
    output logic [31:0]       pc,
    output logic [31:0]       d_pc4,
    output logic [31:0]       d_inst,
    output logic              d_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  hold_inst;
    logic         pend_valid;
    logic [31:0]  pend_pc;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic [31:0]  word;
    logic         fetched;
    logic         redirect;
    logic         ack_in_fetch;

    pipe_npc_sel u_npc_sel (
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .target   (target)
    );

    // Fetch-complete, redirect and PC increment terms shared by FSM and datapath
    always_comb begin
        ack_in_fetch = (state == FETCH) && imem.imem_ack;
        fetched      = ack_in_fetch || (state == HOLD);
        word         = (state == HOLD) ? hold_inst : imem.imem_rdata;
        redirect     = wpcir && d_valid && (pcsource != PCSRC_PC4);
        pc_plus4     = pc + 32'd4;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: park an acked word while ID stalls, resume on consume
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (!wpcir && imem.imem_ack) state_nxt = HOLD;
            HOLD:    if (wpcir) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // FSM outputs: request gated off combinationally during reset
    always_comb begin
        imem.imem_req  = (state == FETCH) && !reset;
        imem.imem_addr = pc;
    end

    // PC, pending redirect, parked word and IF/ID register
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            d_pc4      <= 32'h0;
            d_inst     <= NOP_INST;
            d_valid    <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
            hold_inst  <= NOP_INST;
        end else if (wpcir) begin
            if (fetched) begin
                d_inst     <= word;
                d_pc4      <= pc_plus4;
                d_valid    <= 1'b1;
                pend_valid <= 1'b0;
                if (redirect) begin
                    pc <= target;
                end else if (pend_valid) begin
                    pc <= pend_pc;
                end else begin
                    pc <= pc_plus4;
                end
            end else begin
                d_inst  <= NOP_INST;
                d_valid <= 1'b0;
                if (redirect) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= target;
                end
            end
        end else if (ack_in_fetch) begin
            hold_inst <= imem.imem_rdata;
        end
    end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed scenarios then random traffic
// against a behavioural model of the fetch stage.
module tb_pipe_if_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pcsource;
    logic [31:0] bpc, da, jpc;
    logic        wpcir;
    logic [31:0] pc, d_pc4, d_inst;
    logic        d_valid;

    int n_checks = 0;
    int n_errors = 0;

    pipe_if_stage_if imem ();

    pipe_if_stage dut (
        .clock    (clock),
        .reset    (reset),
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .wpcir    (wpcir),
        .imem     (imem.master),
        .pc       (pc),
        .d_pc4    (d_pc4),
        .d_inst   (d_inst),
        .d_valid  (d_valid)
    );

    always #5 clock = ~clock;

    // Behavioural model: architectural PC, IF/ID contents, a remembered
    // redirect target and a one-word buffer for a word acked during a stall.
    logic [31:0] m_pc, m_dpc4, m_dinst, m_pend_pc, m_buf;
    logic        m_dv, m_pend, m_have_buf;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] ps,
                         input logic [31:0] b, input logic [31:0] d, input logic [31:0] j,
                         input logic a);
        reset    = r;
        wpcir    = w;
        pcsource = ps;
        bpc      = b;
        da       = d;
        jpc      = j;
        imem.imem_ack   = a;
        imem.imem_rdata = a ? word_at(imem.imem_addr) : $urandom;
    endtask

    // One clock: check the bus request, advance the model, clock, check IF/ID
    task automatic cycle();
        logic [31:0] word, tgt;
        logic        got, redir;
        #1;
        chk("imem_req", {31'b0, imem.imem_req}, {31'b0, (!reset && !m_have_buf)});
        if (!reset && !m_have_buf) chk("imem_addr", imem.imem_addr, m_pc);

        if (reset) begin
            m_pc = 0; m_dpc4 = 0; m_dinst = 0; m_dv = 0;
            m_pend = 0; m_pend_pc = 0; m_have_buf = 0; m_buf = 0;
        end else begin
            got   = m_have_buf || imem.imem_ack;
            word  = m_have_buf ? m_buf : imem.imem_rdata;
            tgt   = (pcsource == 2'd1) ? bpc : (pcsource == 2'd2) ? da : jpc;
            redir = wpcir && m_dv && (pcsource != 2'd0);
            if (wpcir && got) begin
                m_dinst    = word;
                m_dpc4     = m_pc + 32'd4;
                m_dv       = 1;
                m_pc       = redir ? tgt : (m_pend ? m_pend_pc : m_pc + 32'd4);
                m_pend     = 0;
                m_have_buf = 0;
            end else if (wpcir) begin
                m_dinst = 0;
                m_dv    = 0;
                if (redir) begin
                    m_pend    = 1;
                    m_pend_pc = tgt;
                end
            end else if (!m_have_buf && imem.imem_ack) begin
                m_have_buf = 1;
                m_buf      = imem.imem_rdata;
            end
        end

        @(posedge clock);
        #1;
        chk("pc", pc, m_pc);
        chk("d_pc4", d_pc4, m_dpc4);
        chk("d_inst", d_inst, m_dinst);
        chk("d_valid", {31'b0, d_valid}, {31'b0, m_dv});
    endtask

    initial begin
        logic r, w, a;
        logic [1:0] ps;
        m_pc = 0; m_dpc4 = 0; m_dinst = 0; m_dv = 0;
        m_pend = 0; m_pend_pc = 0; m_have_buf = 0; m_buf = 0;
        imem.imem_ack = 0; imem.imem_rdata = 0;
        drive(1, 1, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;

        // Reset state
        drive(1, 1, 0, 0, 0, 0, 0); cycle();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, d_valid}, 32'h0);

        // Straight-line fetch 0x0..0x10
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 0, 0, 1); cycle();
            chk("line_pc", pc, 32'(4 * (i + 1)));
            chk("line_dpc4", d_pc4, 32'(4 * (i + 1)));
        end

        // Branch in ID with delay slot at 0x14 acked the same cycle
        drive(0, 1, 2'd1, 32'h40, 0, 0, 1); cycle();
        chk("br_slot", d_inst, word_at(32'h14));
        chk("br_pc", pc, 32'h40);

        // jr redirect while the slot at 0x40 is still outstanding
        drive(0, 1, 2'd2, 32'h0, 32'h80, 0, 0); cycle();
        chk("jr_dvalid", {31'b0, d_valid}, 32'h0);
        chk("jr_pend", {31'b0, dut.pend_valid}, 32'h1);
        chk("jr_pc_hold", pc, 32'h40);
        drive(0, 1, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 0, 0, 0, 0, 0); cycle();
        drive(0, 1, 0, 0, 0, 0, 1); cycle();
        chk("jr_slot", d_inst, word_at(32'h40));
        chk("jr_pc", pc, 32'h80);

        // Load-use stall with the ack arriving in the first stall cycle
        drive(0, 0, 2'd1, 32'h200, 0, 0, 1); cycle();
        chk("stall_pc", pc, 32'h80);
        chk("stall_dinst", d_inst, word_at(32'h40));
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stall_req", {31'b0, imem.imem_req}, 32'h0);
        cycle();
        drive(0, 1, 0, 0, 0, 0, 0); cycle();
        chk("stall_deliver", d_inst, word_at(32'h80));
        chk("stall_pc4", pc, 32'h84);

        // Reset while a fetch at 0x24 is pending; an ack during reset is ignored
        drive(0, 1, 2'd3, 0, 0, 32'h24, 1); cycle();
        chk("j_pc", pc, 32'h24);
        drive(0, 1, 0, 0, 0, 0, 0); cycle();
        drive(1, 1, 0, 0, 0, 0, 1); cycle();
        chk("rstmid_pc", pc, 32'h0);
        chk("rstmid_valid", {31'b0, d_valid}, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("rstmid_req", {31'b0, imem.imem_req}, 32'h0);
        cycle();

        // PC wrap at the top of the address space
        drive(0, 1, 0, 0, 0, 0, 1); cycle();
        drive(0, 1, 2'd3, 0, 0, 32'hFFFF_FFFC, 1); cycle();
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0, 0, 0, 1); cycle();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_dpc4", d_pc4, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(63) == 0);
            w  = ($urandom_range(3) != 0);
            ps = 2'($urandom_range(3));
            if (r) a = 1'($urandom_range(1));
            else   a = !m_have_buf && ($urandom_range(1) == 1);
            drive(r, w, ps, {$urandom, 2'b00} >> 0, {$urandom} & 32'hFFFF_FFFC,
                  {$urandom} & 32'hFFFF_FFFC, a);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
